// File: rtl/reg_op_sequencer.sv
// -----------------------------------------------------------------------------
// reg_op_sequencer
//
// Minimal execute stage placed in front of reg_file. Each command accepted on
// a cmd_valid/cmd_ready handshake reads its source registers, computes a
// BITS-wide result and writes it back to the destination register.
//
// Build option:
//   REG_OP_FLAGS_EN  when defined, flag_z/flag_c track the last retired ALU
//                    op; when undefined, the flag logic is absent and both
//                    flags are tied to 0.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready     command handshake (ready only while idle)
//   cmd_op/rd/rs1/rs2/imm     command fields, captured on the handshake edge
//   RE1/RA1, RE2/RA2          reg_file read ports (single-cycle enables)
//   RD1, RD2                  reg_file read data, valid the cycle after RE
//   WE/WA/WD                  reg_file write port
//   done                      one-cycle pulse when a command retires
//   flag_z, flag_c            zero / carry(borrow) of the last ALU op
// -----------------------------------------------------------------------------
module reg_op_sequencer #(
    parameter int BITS = 4,
    parameter int ADDR = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [2:0]      cmd_op,
    input  logic [ADDR-1:0] cmd_rd,
    input  logic [ADDR-1:0] cmd_rs1,
    input  logic [ADDR-1:0] cmd_rs2,
    input  logic [BITS-1:0] cmd_imm,
    output logic            RE1,
    output logic            RE2,
    output logic [ADDR-1:0] RA1,
    output logic [ADDR-1:0] RA2,
    input  logic [BITS-1:0] RD1,
    input  logic [BITS-1:0] RD2,
    output logic            WE,
    output logic [ADDR-1:0] WA,
    output logic [BITS-1:0] WD,
    output logic            done,
    output logic            flag_z,
    output logic            flag_c
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    // The ALU carries one extra bit only when the carry flag exists.
`ifdef REG_OP_FLAGS_EN
    localparam int AW = BITS + 1;
`else
    localparam int AW = BITS;
`endif

    logic [1:0]      state_reg;
    logic [2:0]      op_reg;
    logic [ADDR-1:0] rd_reg;
    logic [BITS-1:0] imm_reg;
    logic            re1_reg;
    logic            re2_reg;
    logic [ADDR-1:0] ra1_reg;
    logic [ADDR-1:0] ra2_reg;
    logic            we_reg;
    logic [ADDR-1:0] wa_reg;
    logic [BITS-1:0] wd_reg;
    logic            done_reg;
    logic [AW-1:0]   alu_full;
    logic [BITS-1:0] alu_res;

    assign cmd_ready = (state_reg == S_IDLE);
    assign RE1  = re1_reg;
    assign RE2  = re2_reg;
    assign RA1  = ra1_reg;
    assign RA2  = ra2_reg;
    assign WE   = we_reg;
    assign WA   = wa_reg;
    assign WD   = wd_reg;
    assign done = done_reg;

    // Evaluated in EXEC, when RD1/RD2 hold the registers read in READ.
    // Logic ops are zero-extended so their carry bit is always 0.
    always_comb begin
        alu_full = '0;
        case (op_reg)
            OP_ADD:  alu_full = AW'(RD1) + AW'(RD2);
            OP_SUB:  alu_full = AW'(RD1) - AW'(RD2);
            OP_AND:  alu_full = AW'(RD1 & RD2);
            OP_OR:   alu_full = AW'(RD1 | RD2);
            OP_XOR:  alu_full = AW'(RD1 ^ RD2);
            OP_ADDI: alu_full = AW'(RD1) + AW'(imm_reg);
            default: alu_full = '0;
        endcase
    end

    assign alu_res = alu_full[BITS-1:0];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= S_IDLE;
            op_reg    <= '0;
            rd_reg    <= '0;
            imm_reg   <= '0;
            re1_reg   <= 1'b0;
            re2_reg   <= 1'b0;
            ra1_reg   <= '0;
            ra2_reg   <= '0;
            we_reg    <= 1'b0;
            wa_reg    <= '0;
            wd_reg    <= '0;
            done_reg  <= 1'b0;
        end else begin
            // Enables and done are pulses; addresses and data hold.
            re1_reg  <= 1'b0;
            re2_reg  <= 1'b0;
            we_reg   <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_reg  <= cmd_op;
                        rd_reg  <= cmd_rd;
                        imm_reg <= cmd_imm;
                        case (cmd_op)
                            OP_LDI: begin
                                we_reg    <= 1'b1;
                                wa_reg    <= cmd_rd;
                                wd_reg    <= cmd_imm;
                                done_reg  <= 1'b1;
                                state_reg <= S_WB;
                            end
                            OP_NOP: begin
                                done_reg  <= 1'b1;
                                state_reg <= S_WB;
                            end
                            default: begin
                                re1_reg <= 1'b1;
                                ra1_reg <= cmd_rs1;
                                // ADDI has no second register operand.
                                if (cmd_op != OP_ADDI) begin
                                    re2_reg <= 1'b1;
                                    ra2_reg <= cmd_rs2;
                                end
                                state_reg <= S_READ;
                            end
                        endcase
                    end
                end
                S_READ: state_reg <= S_EXEC;
                S_EXEC: begin
                    we_reg    <= 1'b1;
                    wa_reg    <= rd_reg;
                    wd_reg    <= alu_res;
                    done_reg  <= 1'b1;
                    state_reg <= S_WB;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef REG_OP_FLAGS_EN
    logic flag_z_reg;
    logic flag_c_reg;

    // Only ALU ops pass through EXEC, so LDI/NOP leave the flags alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
        end else if (state_reg == S_EXEC) begin
            flag_z_reg <= (alu_res == '0);
            flag_c_reg <= alu_full[BITS];
        end
    end

    assign flag_z = flag_z_reg;
    assign flag_c = flag_c_reg;
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
module tb_reg_op_sequencer;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_LDI  = 3'd5;
    localparam logic [2:0] OP_ADDI = 3'd6;
    localparam logic [2:0] OP_NOP  = 3'd7;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_rd, cmd_rs1, cmd_rs2, cmd_imm;
    logic       RE1, RE2, WE, done, flag_z, flag_c;
    logic [3:0] RA1, RA2, WA, WD;
    logic [3:0] RD1, RD2;

    reg_op_sequencer #(.BITS(4), .ADDR(4)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1),
        .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .RE1(RE1), .RE2(RE2), .RA1(RA1), .RA2(RA2),
        .RD1(RD1), .RD2(RD2),
        .WE(WE), .WA(WA), .WD(WD),
        .done(done), .flag_z(flag_z), .flag_c(flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reg_file: registered read, write on the edge ending WB.
    logic [3:0] mem [16];
    always @(posedge clk) begin
        if (RE1) RD1 <= mem[RA1];
        if (RE2) RD2 <= mem[RA2];
        if (WE)  mem[WA] <= WD;
    end

    typedef struct {
        logic [2:0] op;
        logic [3:0] rd, rs1, rs2, imm;
        logic       we;
        logic [3:0] wd;
        logic       z, c;
    } vec_t;

    typedef struct {
        logic       we;
        logic [3:0] wa, wd;
        logic       z, c;
    } exp_t;

    exp_t scb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic fl(input logic v);
`ifdef REG_OP_FLAGS_EN
        return v;
`else
        return 1'b0 & v;
`endif
    endfunction

    function automatic exp_t mk(input logic we, input logic [3:0] wa,
                                input logic [3:0] wd, input logic z, input logic c);
        exp_t e;
        e.we = we; e.wa = wa; e.wd = wd; e.z = fl(z); e.c = fl(c);
        return e;
    endfunction

    // Retirement monitor: every done pops one expected record.
    always @(negedge clk) begin
        if (rstn) begin
            if (done) begin
                if (scb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = scb.pop_front();
                    $display("retire: WE=%0d WA=%0h WD=%0h z=%0d c=%0d", WE, WA, WD, flag_z, flag_c);
                    chk("we", int'(WE), int'(e.we));
                    if (e.we) begin
                        chk("wa", int'(WA), int'(e.wa));
                        chk("wd", int'(WD), int'(e.wd));
                    end
                    chk("flag_z", int'(flag_z), int'(e.z));
                    chk("flag_c", int'(flag_c), int'(e.c));
                end
            end else if (WE) begin
                chk("stray_we", 1, 0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                         input logic [3:0] rs2, input logic [3:0] imm,
                         input logic push, input exp_t e);
        int t;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) chk("ready_timeout", 0, 1);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        if (push) scb.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{OP_LDI,  4'd3,  4'd0, 4'd0, 4'hA, 1'b1, 4'hA, 1'b0, 1'b0};
        tbl[1]  = '{OP_LDI,  4'd2,  4'd0, 4'd0, 4'h9, 1'b1, 4'h9, 1'b0, 1'b0};
        tbl[2]  = '{OP_LDI,  4'd3,  4'd0, 4'd0, 4'h8, 1'b1, 4'h8, 1'b0, 1'b0};
        tbl[3]  = '{OP_LDI,  4'd5,  4'd0, 4'd0, 4'h5, 1'b1, 4'h5, 1'b0, 1'b0};
        tbl[4]  = '{OP_ADD,  4'd1,  4'd2, 4'd3, 4'h0, 1'b1, 4'h1, 1'b0, 1'b1};
        tbl[5]  = '{OP_SUB,  4'd4,  4'd5, 4'd5, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[6]  = '{OP_LDI,  4'd6,  4'd0, 4'd0, 4'h2, 1'b1, 4'h2, 1'b1, 1'b0};
        tbl[7]  = '{OP_LDI,  4'd7,  4'd0, 4'd0, 4'h7, 1'b1, 4'h7, 1'b1, 1'b0};
        tbl[8]  = '{OP_SUB,  4'd8,  4'd6, 4'd7, 4'h0, 1'b1, 4'hB, 1'b0, 1'b1};
        tbl[9]  = '{OP_AND,  4'd9,  4'd2, 4'd3, 4'h0, 1'b1, 4'h8, 1'b0, 1'b0};
        tbl[10] = '{OP_OR,   4'd10, 4'd1, 4'd4, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};
        tbl[11] = '{OP_XOR,  4'd11, 4'd2, 4'd2, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0};
        tbl[12] = '{OP_ADDI, 4'd12, 4'd2, 4'd0, 4'hF, 1'b1, 4'h8, 1'b0, 1'b1};
        tbl[13] = '{OP_NOP,  4'd0,  4'd0, 4'd0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1};
        tbl[14] = '{OP_ADD,  4'd2,  4'd2, 4'd2, 4'h0, 1'b1, 4'h2, 1'b0, 1'b1};
        tbl[15] = '{OP_ADDI, 4'd13, 4'd8, 4'd0, 4'h5, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[16] = '{OP_LDI,  4'd0,  4'd0, 4'd0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b1};
        tbl[17] = '{OP_SUB,  4'd14, 4'd2, 4'd1, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0};

        rstn = 1'b0; cmd_valid = 1'b0;
        cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", int'(WE), 0);
        chk("rst_done", int'(done), 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_re1", int'(RE1), 0);
        chk("rst_re2", int'(RE2), 0);
        chk("rst_ra", int'({RA1, RA2}), 0);
        chk("rst_wa_wd", int'({WA, WD}), 0);
        chk("rst_flags", int'({flag_z, flag_c}), 0);
        repeat (3) @(negedge clk);

        // Table-driven commands; the monitor checks each retirement.
        for (int i = 0; i < 18; i++) begin
            $display("vec %0d: op=%0d rd=%0h rs1=%0h rs2=%0h imm=%0h", i,
                     tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            issue(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, 1'b1,
                  mk(tbl[i].we, tbl[i].rd, tbl[i].wd, tbl[i].z, tbl[i].c));
        end

        // ADD timing: r1 = r2(2) + r3(8) = A.
        issue(OP_ADD, 4'd1, 4'd2, 4'd3, 4'h0, 1'b1, mk(1'b1, 4'd1, 4'hA, 1'b0, 1'b0));
        @(negedge clk);
        chk("add_c1_re", int'({RE1, RE2}), 3);
        chk("add_c1_ra", int'({RA1, RA2}), 8'h23);
        chk("add_c1_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("add_c2_re_we", int'({RE1, RE2, WE}), 0);
        chk("add_c2_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("add_c3_we_done", int'({WE, done}), 3);
        chk("add_c3_ready", int'(cmd_ready), 0);
        @(negedge clk);
        chk("add_c4_ready", int'(cmd_ready), 1);
        chk("add_c4_we", int'(WE), 0);

        // ADDI reads only rs1: r12 = r2(2) + 1 = 3.
        issue(OP_ADDI, 4'd12, 4'd2, 4'd7, 4'h1, 1'b1, mk(1'b1, 4'd12, 4'h3, 1'b0, 1'b0));
        @(negedge clk);
        chk("addi_re", int'({RE1, RE2}), 2);
        chk("addi_ra1", int'(RA1), 2);

        // Three back-to-back ADDs with cmd_valid held: r15 = r2(2) + r1(A) = C.
        @(negedge clk);
        while (!cmd_ready) @(negedge clk);
        cmd_op = OP_ADD; cmd_rd = 4'd15; cmd_rs1 = 4'd2; cmd_rs2 = 4'd1; cmd_imm = 4'h0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) scb.push_back(mk(1'b1, 4'd15, 4'hC, 1'b0, 1'b0));
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_we_%0d", k), int'(WE), int'((k % 4) == 3));
            chk($sformatf("b2b_ready_%0d", k), int'(cmd_ready), int'((k % 4) == 0));
            if (k == 9) cmd_valid = 1'b0;
        end

        // Reset during EXEC of ADD r9 = r2 + r3; r9 must keep 8.
        issue(OP_ADD, 4'd9, 4'd2, 4'd3, 4'h0, 1'b0, mk(1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_en", int'({RE1, RE2, WE, done}), 0);
        chk("mid_rst_ra", int'({RA1, RA2}), 0);
        chk("mid_rst_wa_wd", int'({WA, WD}), 0);
        chk("mid_rst_flags", int'({flag_z, flag_c}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        chk("mid_rst_we", int'(WE), 0);
        issue(OP_OR, 4'd10, 4'd9, 4'd0, 4'h0, 1'b1, mk(1'b1, 4'd10, 4'h8, 1'b0, 1'b0));

        // LDI timing: result visible the cycle after accept.
        issue(OP_LDI, 4'd3, 4'd0, 4'd0, 4'hA, 1'b1, mk(1'b1, 4'd3, 4'hA, 1'b0, 1'b0));
        @(negedge clk);
        chk("ldi_c1_we_done", int'({WE, done}), 3);
        chk("ldi_c1_wa_wd", int'({WA, WD}), 8'h3A);
        @(negedge clk);
        chk("ldi_c2_ready", int'(cmd_ready), 1);
        chk("ldi_c2_we", int'(WE), 0);

        for (int t = 0; t < 100 && scb.size() != 0; t++) @(negedge clk);
        if (scb.size() != 0) chk("drain_timeout", scb.size(), 0);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/reg_op_sequencer.md
# reg_op_sequencer

Command-driven sequencer that sits directly upstream of the team's register file (`reg_file`) and drives its read and write ports. It accepts one register-to-register operation per valid/ready handshake and reads the source registers. It computes a BITS-wide result and writes it back to the destination register. It is the minimal execute stage that turns the register file into a usable datapath.

## Interface
Parameters:
- BITS, 4, data width; must match `reg_file` BITS.
- ADDR, 4, register address width; must match `reg_file` ADDR.

Ports:
- clk  input  1  clock; everything is sampled on the rising edge.
- rstn  input  1  reset, asynchronous and active-low.
- cmd_valid  input  1  a command is presented.
- cmd_ready  output  1  the sequencer can accept a command (IDLE only).
- cmd_op  input  3  opcode (see Operation).
- cmd_rd  input  ADDR  destination register.
- cmd_rs1  input  ADDR  source register 1.
- cmd_rs2  input  ADDR  source register 2.
- cmd_imm  input  BITS  immediate operand.
- RE1, RE2  output  1  read enables to `reg_file`.
- RA1, RA2  output  ADDR  read addresses to `reg_file`.
- RD1, RD2  input  BITS  read data from `reg_file`; valid in the cycle after RE is high.
- WE  output  1  write enable to `reg_file`.
- WA  output  ADDR  write address.
- WD  output  BITS  write data.
- done  output  1  one-cycle pulse when a command retires.
- flag_z  output  1  result of the last retired ALU op was zero.
- flag_c  output  1  carry or borrow of the last retired ADD, SUB or ADDI.

## Operation
- Opcodes:
  - 0 ADD: rd = rs1 + rs2.
  - 1 SUB: rd = rs1 - rs2.
  - 2 AND: rd = rs1 & rs2.
  - 3 OR: rd = rs1 | rs2.
  - 4 XOR: rd = rs1 ^ rs2.
  - 5 LDI: rd = imm.
  - 6 ADDI: rd = rs1 + imm.
  - 7 NOP: no write.
- Arithmetic is modulo 2^BITS. Carry is bit BITS of the (BITS+1)-bit sum. For SUB, carry is the borrow, set when rs1 < rs2 unsigned.
- A handshake occurs on a rising edge where cmd_valid && cmd_ready. All cmd_* fields are captured on that edge; inputs are ignored at all other times.
- State machine:
  - IDLE to READ on accept, for ops 0 to 4 and 6.
  - IDLE to WB on accept, for LDI and NOP.
  - READ to EXEC, then EXEC to WB, then WB to IDLE, each unconditionally.
- READ: RE1 = 1 with RA1 = rs1. RE2 = 1 with RA2 = rs2 for ops 0 to 4 only; ADDI keeps RE2 = 0.
- EXEC: RD1 and RD2 are consumed, and the result and flags are computed into registers.
- WB: WE = 1, WA = rd, WD = result, done = 1. For NOP, WE = 0 and done = 1.
- rd equal to rs1 or rs2 is legal. The read completes before the write, so old values are used.
- All outputs are registered; there are no combinational paths from cmd_* to the `reg_file` ports.

## Timing
- Reset (async assert): state = IDLE. RE1, RE2, WE, done, RA1, RA2, WA, WD, flag_z and flag_c are all 0. cmd_ready = 1 once rstn is high.
- rstn asserted mid-operation: the command is abandoned, no WE pulse is issued, and flags are cleared.
- ALU op accepted at edge E0:
  - cycle after E0: RE high.
  - next cycle: EXEC.
  - third cycle: WE and done high; `reg_file` writes on the edge ending WB.
- LDI or NOP accepted at E0: WE (LDI) and done are high in the cycle after E0.
- cmd_ready is low in READ, EXEC and WB. Back-to-back ALU throughput is one op per 4 cycles; LDI is one per 2 cycles.
- RE1, RE2, WE and done are single-cycle pulses. RA*, WA and WD hold their last values when not enabled.
- Flags update on the edge entering WB for ops 0 to 4 and 6.
  - AND, OR and XOR clear flag_c.
  - LDI and NOP leave both flags unchanged.

## Configuration
- Macro: REG_OP_FLAGS_EN.
- Defined: flag_z and flag_c behave as specified above.
- Undefined: the flag logic is not synthesized, and flag_z and flag_c are tied to 0. The ports are retained in both cases.

## Test plan
All scenarios use BITS = 4, ADDR = 4, with a behavioural `reg_file` model attached.
- rstn low for 2 cycles, then release -> all outputs 0, cmd_ready = 1, no WE while idle.
- LDI rd = 3, imm = 0xA -> the next cycle shows WE = 1, WA = 3, WD = 0xA, done = 1; cmd_ready returns to 1.
- ADD rd = 1, rs1 = 2 (0x9), rs2 = 3 (0x8) -> RE1 = RE2 = 1 with RA1 = 2 and RA2 = 3 for one cycle. Two cycles later WD = 0x1, WA = 1. With REG_OP_FLAGS_EN: flag_c = 1, flag_z = 0.
- SUB rd = 4, rs1 = rs2 = 5 (0x5) -> WD = 0x0, flag_z = 1, flag_c = 0. Then SUB of 0x2 - 0x7 -> WD = 0xB, flag_c = 1.
- cmd_valid held high with 3 queued ADDs -> cmd_ready is low in READ, EXEC and WB. Exactly one WE per op, at cycles 3, 7 and 11 after the first accept.
- rstn pulsed low during EXEC of an ADD -> all outputs drop to 0 immediately, no WE occurs, and the destination register is unchanged.
